// File: rtl/bwzz_pkg.sv
// Shared types and widths for the interrupt entry sequencer.
package bwzz_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 16;
    localparam int unsigned FLAG_W = 4;

    // Kind of micro-op injected into decode during interrupt entry.
    localparam logic [1:0] INJ_NONE  = 2'd0;
    localparam logic [1:0] INJ_PC_HI = 2'd1;
    localparam logic [1:0] INJ_PC_LO = 2'd2;
    localparam logic [1:0] INJ_FLAGS = 2'd3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_SAFE  = 3'd1,
        DRAIN      = 3'd2,
        PUSH_HI    = 3'd3,
        PUSH_LO    = 3'd4,
        PUSH_FLAGS = 3'd5,
        REDIRECT   = 3'd6,
        IN_ISR     = 3'd7
    } isr_state_t;

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector with a sticky pending flag for the external interrupt.
module irq_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic take,
    output logic pending,
    output logic riseEdge_c
);

    logic intQ;

    assign riseEdge_c = irq & ~intQ;

    // Remember the previous sample; a new edge wins over a same-cycle take.
    always_ff @(posedge clk) begin
        if (reset) begin
            intQ    <= 1'b0;
            pending <= 1'b0;
        end else begin
            intQ    <= irq;
            pending <= (pending & ~take) | riseEdge_c;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry controller: freeze fetch, wait for a safe point, drain,
// inject PC/flags pushes, redirect to the vector and track ISR residency.
module interrupt_sequencer
    import bwzz_pkg::*;
#(
    parameter logic [PC_W-1:0] VECTOR_ADDR  = 32'h0000_0000,
    parameter int unsigned     DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              interrupt,
    input  logic [PC_W-1:0]   next_pc,
    input  logic [FLAG_W-1:0] flags,
    input  logic              flush,
    input  logic              two_word_pending,
    input  logic              stall,
    input  logic              rti_decoded,
    output logic              fetch_hold,
    output logic [1:0]        inject_kind,
    output logic [INST_W-1:0] inject_data,
    output logic              save_flags,
    output logic [PC_W-1:0]   saved_pc,
    output logic              pc_redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              in_isr
);

    localparam int unsigned CNT_W = 4;

    isr_state_t         state;
    logic [CNT_W-1:0]   drainCnt;
    logic [FLAG_W-1:0]  flagsQ;
    logic               pending;
    logic               riseEdge_c;
    logic               takeIrq_c;

    // The request is consumed on the DRAIN -> PUSH_HI transition.
    assign takeIrq_c = (state == DRAIN) && !stall && (drainCnt == '0);

    irq_edge_latch u_edge (
        .clk        (clk),
        .reset      (reset),
        .irq        (interrupt),
        .take       (takeIrq_c),
        .pending    (pending),
        .riseEdge_c (riseEdge_c)
    );

    // Sequencer FSM; outputs are loaded together with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            drainCnt    <= '0;
            saved_pc    <= '0;
            flagsQ      <= '0;
            fetch_hold  <= 1'b0;
            inject_kind <= INJ_NONE;
            inject_data <= '0;
            save_flags  <= 1'b0;
            pc_redirect <= 1'b0;
            redirect_pc <= VECTOR_ADDR;
            in_isr      <= 1'b0;
        end else begin
            save_flags  <= 1'b0;
            redirect_pc <= VECTOR_ADDR;
            case (state)
                IDLE: begin
                    if (pending || riseEdge_c) begin
                        state      <= WAIT_SAFE;
                        fetch_hold <= 1'b1;
                    end
                end
                WAIT_SAFE: begin
                    if (!(flush || two_word_pending || stall)) begin
                        saved_pc   <= next_pc;
                        flagsQ     <= flags;
                        save_flags <= 1'b1;
                        drainCnt   <= CNT_W'(DRAIN_CYCLES - 1);
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (drainCnt == '0) begin
                            state       <= PUSH_HI;
                            inject_kind <= INJ_PC_HI;
                            inject_data <= saved_pc[PC_W-1:INST_W];
                        end else begin
                            drainCnt <= drainCnt - CNT_W'(1);
                        end
                    end
                end
                PUSH_HI: begin
                    if (!stall) begin
                        state       <= PUSH_LO;
                        inject_kind <= INJ_PC_LO;
                        inject_data <= saved_pc[INST_W-1:0];
                    end
                end
                PUSH_LO: begin
                    if (!stall) begin
                        state       <= PUSH_FLAGS;
                        inject_kind <= INJ_FLAGS;
                        inject_data <= INST_W'(flagsQ);
                    end
                end
                PUSH_FLAGS: begin
                    if (!stall) begin
                        state       <= REDIRECT;
                        fetch_hold  <= 1'b0;
                        inject_kind <= INJ_NONE;
                        inject_data <= '0;
                        pc_redirect <= 1'b1;
                    end
                end
                REDIRECT: begin
                    state       <= IN_ISR;
                    pc_redirect <= 1'b0;
                    in_isr      <= 1'b1;
                end
                IN_ISR: begin
                    if (rti_decoded) begin
                        state  <= IDLE;
                        in_isr <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    fetch_hold  <= 1'b0;
                    inject_kind <= INJ_NONE;
                    inject_data <= '0;
                    pc_redirect <= 1'b0;
                    in_isr      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: expected output events are queued
// by the stimulus and matched by an independent negedge monitor.
module tb_interrupt_sequencer;

    localparam logic [31:0] VEC = 32'h0000_8000;
    localparam int NONE = -100;

    localparam int T_HOLD  = 0;
    localparam int T_SAVE  = 1;
    localparam int T_INJ   = 2;
    localparam int T_REDIR = 3;
    localparam int T_ISR   = 4;

    typedef struct {
        int          cyc;
        int          tag;
        logic [31:0] val;
    } ev_t;

    ev_t expQ[$];
    int  nCmp = 0;
    int  nBad = 0;
    int  cyc  = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        interrupt = 1'b0;
    logic [31:0] next_pc = '0;
    logic [3:0]  flags = '0;
    logic        flush = 1'b0;
    logic        two_word_pending = 1'b0;
    logic        stall = 1'b0;
    logic        rti_decoded = 1'b0;
    logic        fetch_hold;
    logic [1:0]  inject_kind;
    logic [15:0] inject_data;
    logic        save_flags;
    logic [31:0] saved_pc;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        in_isr;

    logic prevHold = 1'b0;
    logic prevIsr  = 1'b0;

    interrupt_sequencer #(
        .VECTOR_ADDR  (VEC),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .interrupt        (interrupt),
        .next_pc          (next_pc),
        .flags            (flags),
        .flush            (flush),
        .two_word_pending (two_word_pending),
        .stall            (stall),
        .rti_decoded      (rti_decoded),
        .fetch_hold       (fetch_hold),
        .inject_kind      (inject_kind),
        .inject_data      (inject_data),
        .save_flags       (save_flags),
        .saved_pc         (saved_pc),
        .pc_redirect      (pc_redirect),
        .redirect_pc      (redirect_pc),
        .in_isr           (in_isr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string tagName(input int tag);
        case (tag)
            T_HOLD:  return "fetch_hold";
            T_SAVE:  return "save_flags/saved_pc";
            T_INJ:   return "inject";
            T_REDIR: return "pc_redirect";
            T_ISR:   return "in_isr";
            default: return "?";
        endcase
    endfunction

    task automatic expEv(input int c, input int tag, input logic [31:0] val);
        ev_t e;
        e.cyc = c;
        e.tag = tag;
        e.val = val;
        expQ.push_back(e);
    endtask

    // Expected events of one entry: sampled at edge b, B blocked cycles, S stalled PUSH_LO cycles.
    task automatic expEntry(input int b, input int B, input int S,
                            input logic [31:0] pc, input logic [3:0] fl);
        expEv(b, T_HOLD, 32'd1);
        expEv(b + 1 + B, T_SAVE, pc);
        expEv(b + 3 + B, T_INJ, {14'b0, 2'd1, pc[31:16]});
        for (int i = 0; i <= S; i++)
            expEv(b + 4 + B + i, T_INJ, {14'b0, 2'd2, pc[15:0]});
        expEv(b + 5 + B + S, T_INJ, {14'b0, 2'd3, 12'b0, fl});
        expEv(b + 6 + B + S, T_HOLD, 32'd0);
        expEv(b + 6 + B + S, T_REDIR, VEC);
        expEv(b + 7 + B + S, T_ISR, 32'd1);
    endtask

    task automatic observe(input int tag, input logic [31:0] val);
        ev_t e;
        nCmp++;
        if (expQ.size() == 0) begin
            nBad++;
            $display("FAIL unexpected %s: got %h at cycle %0d, required no event",
                     tagName(tag), val, cyc);
        end else begin
            e = expQ.pop_front();
            if (e.cyc != cyc || e.tag != tag || e.val !== val) begin
                nBad++;
                $display("FAIL %s: got %s=%h at cycle %0d, required %s=%h at cycle %0d",
                         tagName(e.tag), tagName(tag), val, cyc, tagName(e.tag), e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every visible output event is matched against the queue head.
    always @(negedge clk) begin
        if (fetch_hold !== prevHold) observe(T_HOLD, {31'b0, fetch_hold});
        if (save_flags === 1'b1)     observe(T_SAVE, saved_pc);
        if (inject_kind !== 2'd0)    observe(T_INJ, {14'b0, inject_kind, inject_data});
        if (pc_redirect === 1'b1)    observe(T_REDIR, redirect_pc);
        if (in_isr !== prevIsr)      observe(T_ISR, {31'b0, in_isr});
        prevHold = fetch_hold;
        prevIsr  = in_isr;
    end

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] req);
        nCmp++;
        if (got !== req) begin
            nBad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkEmpty(input string name);
        nCmp++;
        if (expQ.size() != 0) begin
            nBad++;
            $display("FAIL %s: got %0d events still expected, required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic checkAllZero(input string name);
        checkVal({name, " fetch_hold"},  {31'b0, fetch_hold}, 32'd0);
        checkVal({name, " inject_kind"}, {30'b0, inject_kind}, 32'd0);
        checkVal({name, " inject_data"}, {16'b0, inject_data}, 32'd0);
        checkVal({name, " save_flags"},  {31'b0, save_flags}, 32'd0);
        checkVal({name, " saved_pc"},    saved_pc, 32'd0);
        checkVal({name, " pc_redirect"}, {31'b0, pc_redirect}, 32'd0);
        checkVal({name, " in_isr"},      {31'b0, in_isr}, 32'd0);
        checkVal({name, " redirect_pc"}, redirect_pc, VEC);
    endtask

    // Drives cycles r=-1..len-1 relative to edge b; event times r are the sampling edge.
    task automatic runSeq(input logic [31:0] pcA, input logic [31:0] pcB, input int pcSwitch,
                          input logic [3:0] fl,
                          input int fLo, input int fHi, input int tLo, input int tHi,
                          input int sLo, input int sHi,
                          input int rtiAt, input int rti2At, input int irq2At,
                          input int rstAt, input int len);
        for (int r = -1; r < len; r++) begin
            interrupt        = (r == -1) || (r == irq2At - 1);
            flush            = (r >= fLo) && (r <= fHi);
            two_word_pending = (r >= tLo) && (r <= tHi);
            stall            = (r >= sLo) && (r <= sHi);
            rti_decoded      = (r == rtiAt - 1) || (r == rti2At - 1);
            reset            = (r == rstAt - 1);
            next_pc          = (r < pcSwitch) ? pcA : pcB;
            flags            = fl;
            tick();
        end
        interrupt        = 1'b0;
        flush            = 1'b0;
        two_word_pending = 1'b0;
        stall            = 1'b0;
        rti_decoded      = 1'b0;
        reset            = 1'b0;
    endtask

    initial begin : stim
        int b;

        // Reset values
        tick();
        tick();
        tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();
        tick();

        // Basic entry
        b = cyc + 1;
        expEntry(b, 0, 0, 32'h0001_2345, 4'b1010);
        expEv(b + 10, T_ISR, 32'd0);
        runSeq(32'h0001_2345, 32'h0001_2345, 0, 4'b1010,
               1, 0, 1, 0, 1, 0, 10, NONE, NONE, NONE, 14);
        repeat (3) tick();
        checkEmpty("basic drain");

        // Safe point: flush 3 cycles then two_word_pending 2 cycles; PC changes only once clear
        b = cyc + 1;
        expEntry(b, 5, 0, 32'hCAFE_0F0F, 4'b0101);
        expEv(b + 20, T_ISR, 32'd0);
        runSeq(32'hDEAD_BEEF, 32'hCAFE_0F0F, 5, 4'b0101,
               0, 2, 3, 4, 1, 0, 20, NONE, NONE, NONE, 24);
        repeat (3) tick();
        checkEmpty("safe drain");

        // Stall for 4 cycles while PUSH_LO is presented
        b = cyc + 1;
        expEntry(b, 0, 4, 32'h89AB_CDEF, 4'b0011);
        expEv(b + 15, T_ISR, 32'd0);
        runSeq(32'h89AB_CDEF, 32'h89AB_CDEF, 0, 4'b0011,
               1, 0, 1, 0, 4, 7, 15, NONE, NONE, NONE, 18);
        repeat (3) tick();
        checkEmpty("stall drain");

        // Edge during ISR, RTI later: one IDLE cycle then a second entry
        b = cyc + 1;
        expEntry(b, 0, 0, 32'h1111_2222, 4'b1111);
        expEv(b + 11, T_ISR, 32'd0);
        expEntry(b + 12, 0, 0, 32'h1111_2222, 4'b1111);
        expEv(b + 24, T_ISR, 32'd0);
        runSeq(32'h1111_2222, 32'h1111_2222, 0, 4'b1111,
               1, 0, 1, 0, 1, 0, 11, 24, 9, NONE, 30);
        repeat (3) tick();
        checkEmpty("nested drain");

        // Edge and RTI in the same ISR cycle
        b = cyc + 1;
        expEntry(b, 0, 0, 32'h0F0F_A5A5, 4'b0110);
        expEv(b + 11, T_ISR, 32'd0);
        expEntry(b + 12, 0, 0, 32'h0F0F_A5A5, 4'b0110);
        expEv(b + 24, T_ISR, 32'd0);
        runSeq(32'h0F0F_A5A5, 32'h0F0F_A5A5, 0, 4'b0110,
               1, 0, 1, 0, 1, 0, 11, 24, 11, NONE, 30);
        repeat (3) tick();
        checkEmpty("same-cycle drain");

        // Reset during PUSH_LO aborts the entry
        b = cyc + 1;
        expEv(b, T_HOLD, 32'd1);
        expEv(b + 1, T_SAVE, 32'h7654_3210);
        expEv(b + 3, T_INJ, 32'h0001_7654);
        expEv(b + 4, T_INJ, 32'h0002_3210);
        expEv(b + 5, T_HOLD, 32'd0);
        runSeq(32'h7654_3210, 32'h7654_3210, 0, 4'b1001,
               1, 0, 1, 0, 1, 0, NONE, NONE, NONE, 5, 5);
        checkAllZero("mid reset");
        repeat (6) tick();
        checkEmpty("reset drain");

        // Normal entry after the abort
        b = cyc + 1;
        expEntry(b, 0, 0, 32'h0000_ABCD, 4'b0001);
        expEv(b + 9, T_ISR, 32'd0);
        runSeq(32'h0000_ABCD, 32'h0000_ABCD, 0, 4'b0001,
               1, 0, 1, 0, 1, 0, 9, NONE, NONE, NONE, 12);
        repeat (3) tick();
        checkEmpty("post-reset drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
